sequential_integral: RTL and testbench
======================================

# sequential_integral

Sequential monomial integrator: accepts a term `coeff·x^expo` and returns `(coeff/(expo+1))·x^(expo+1)`, the inverse of the calculator's derivative stage. It computes the quotient with an iterative 8-step restoring divider and also reports the remainder, so the exact result is `(quot + rem/(expo+1))·x^(expo+1)`. It sits beside the derivative block in the calculator datapath, takes 8-bit operands (the derivative block's output width), and uses a valid/ready handshake on both sides.

## Interface
- No parameters; all widths are fixed at 8 bits.
- `clk` input 1: single clock; all state changes on the rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `in_valid` input 1: input term is valid.
- `in_ready` output 1: block can accept a term.
- `coeff` input 8: unsigned coefficient.
- `expo` input 8: unsigned exponent.
- `out_valid` output 1: result is valid.
- `out_ready` input 1: downstream accepts the result.
- `quot` output 8: `floor(coeff/(expo+1))`, or the rounded value if `INTEGRAL_ROUND_EN` is defined.
- `rem` output 8: `coeff mod (expo+1)`; always the true, unrounded remainder.
- `expo_out` output 8: `expo+1`, modulo 256.
- `ovf` output 1: `expo` was 255, so `expo_out` wrapped to 0.

## Operation
- FSM states: IDLE, DIV, DONE. Reset state is IDLE.
- **Reset values:**
  - `in_ready=1`, `out_valid=0`, `ovf=0`.
  - `quot=0`, `rem=0`, `expo_out=0`.
  - Internal 4-bit step counter = 0.
- **IDLE:**
  - `in_ready=1`.
  - On `in_valid`, the input is captured.
  - Divisor `d = {1'b0,expo} + 1` is formed at 9 bits, so `expo=255` gives `d=256`.
  - `expo_out` and `ovf` are latched at capture.
  - If `coeff==0`: `quot=0`, `rem=0`, next state DONE (fast path).
  - Otherwise: next state DIV, with counter=0, partial remainder=0, dividend shift register=`coeff`.
- **DIV:**
  - `in_ready=0`.
  - One restoring step per cycle, MSB first.
  - Step: `r9 = {r,next_dividend_bit}`; if `r9 >= d`, then `r = r9 - d` and the quotient bit is 1; otherwise `r = r9` and the quotient bit is 0.
  - The partial remainder is held at 9 bits, so the `d=256` case needs no special logic: it yields `quot=0`, `rem=coeff`.
  - After the 8th step, `quot` and `rem` are registered and the next state is DONE.
- **DONE:**
  - `out_valid=1` and `in_ready=0`.
  - Outputs are held stable while `out_ready=0`.
  - On `out_ready=1`, next state is IDLE and `out_valid` drops.
  - A new input cannot be accepted in the same cycle as the output handshake.
- `in_valid` is ignored outside IDLE.
- `quot`, `rem`, `expo_out` and `ovf` keep their last values after the handshake until the next result is produced.

## Timing
- Input capture occurs on edge T, where `in_valid & in_ready` is high.
- **General path:** DIV steps occur on edges T+1 … T+8. `out_valid` is high after edge T+8, giving 8-cycle latency.
- **Zero-coefficient fast path:** `out_valid` is high after edge T+1, giving 1-cycle latency.
- **Throughput:** one term per 10 cycles at most on the general path (capture, 8 steps, output handshake, plus IDLE). Zero-coefficient terms take 3 cycles.
- **Asynchronous `rst` mid-DIV or mid-DONE:** all outputs return to their reset values immediately. The term in flight is discarded and no `out_valid` is produced for it.
- **`rst` deassertion:** first capture is possible on the first edge after deassertion.
- No combinational path exists from `in_valid` or `out_ready` to any output.

## Configuration
- Macro: `INTEGRAL_ROUND_EN`.
- **Defined:** `quot` is rounded to nearest, half up. If `2·rem >= d`, then `quot = truncated_quot + 1`. This is evaluated on the final DIV step, so it adds no extra cycle. Overflow is impossible because `d>=2` whenever `rem>0`.
- **Undefined:** `quot` is truncated (floor). The rounding comparator is not built.
- `rem`, `expo_out`, `ovf` and all timing are identical in both builds.

## Test plan
- `coeff=12`, `expo=2`, `out_ready=1` → 8 cycles later: `quot=4`, `rem=0`, `expo_out=3`, `ovf=0`.
- `coeff=7`, `expo=1` → `quot=3`, `rem=1`, `expo_out=2`. With `INTEGRAL_ROUND_EN` defined: `quot=4`, `rem=1`.
- `coeff=0`, `expo=5` → `out_valid` 1 cycle after capture, with `quot=0`, `rem=0`, `expo_out=6`.
- `coeff=200`, `expo=255` → `quot=0`, `rem=200`, `expo_out=0`, `ovf=1`.
- `coeff=255`, `expo=0`, `out_ready` held 0 for 5 cycles → `quot=255` and `rem=0` stay stable with `out_valid=1` and `in_ready=0`. A new `in_valid` during the stall is ignored. IDLE is reached one cycle after `out_ready` rises.
- `rst` pulsed on the 4th DIV cycle → immediately `in_ready=1`, `out_valid=0`, all outputs 0. No result is emitted. A subsequent `coeff=9`, `expo=2` gives `quot=3`, `rem=0`, `expo_out=3`.

Source files
------------

// File: rtl/sequential_integral.sv
// Sequential monomial integrator: coeff*x^expo -> (coeff/(expo+1))*x^(expo+1) via an 8-step restoring divider.
// Optional macro INTEGRAL_ROUND_EN rounds the quotient half-up instead of truncating it.
module sequential_integral (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] coeff,
  input  logic [7:0] expo,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] quot,
  output logic [7:0] rem,
  output logic [7:0] expo_out,
  output logic       ovf
);

  typedef enum logic [1:0] {IDLE, DIV, DONE} state_t;

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [8:0] d_q, d_d;
  logic [8:0] r_q, r_d;
  logic [7:0] dvd_q, dvd_d;
  logic [6:0] qacc_q, qacc_d;
  logic       in_ready_q, in_ready_d;
  logic       out_valid_q, out_valid_d;
  logic [7:0] quot_q, quot_d;
  logic [7:0] rem_q, rem_d;
  logic [7:0] expo_out_q, expo_out_d;
  logic       ovf_q, ovf_d;

  // One restoring step; the 10-bit shifted remainder covers the d=256 case without special handling.
  logic [9:0] r_shift;
  logic       q_bit;
  logic [8:0] r_step;
  logic [7:0] q_trunc;
  logic [7:0] q_final;

  always_comb begin
    r_shift = {r_q, dvd_q[7]};
    q_bit   = (r_shift >= {1'b0, d_q});
    r_step  = q_bit ? (r_shift[8:0] - d_q) : r_shift[8:0];
    q_trunc = {qacc_q, q_bit};
`ifdef INTEGRAL_ROUND_EN
    q_final = ({r_step, 1'b0} >= {1'b0, d_q}) ? (q_trunc + 8'd1) : q_trunc;
`else
    q_final = q_trunc;
`endif
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    d_d         = d_q;
    r_d         = r_q;
    dvd_d       = dvd_q;
    qacc_d      = qacc_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    quot_d      = quot_q;
    rem_d       = rem_q;
    expo_out_d  = expo_out_q;
    ovf_d       = ovf_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          d_d        = {1'b0, expo} + 9'd1;
          expo_out_d = expo + 8'd1;
          ovf_d      = (expo == 8'hFF);
          r_d        = '0;
          qacc_d     = '0;
          dvd_d      = coeff;
          // A zero coefficient runs only the final step, which yields quot=0, rem=0.
          cnt_d      = (coeff == 8'd0) ? 4'd7 : 4'd0;
          in_ready_d = 1'b0;
          state_d    = DIV;
        end
      end
      DIV: begin
        r_d    = r_step;
        qacc_d = {qacc_q[5:0], q_bit};
        dvd_d  = {dvd_q[6:0], 1'b0};
        cnt_d  = cnt_q + 4'd1;
        if (cnt_q == 4'd7) begin
          quot_d      = q_final;
          rem_d       = r_step[7:0];
          out_valid_d = 1'b1;
          state_d     = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = IDLE;
        end
      end
      default: begin
        out_valid_d = 1'b0;
        in_ready_d  = 1'b1;
        state_d     = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      d_q         <= '0;
      r_q         <= '0;
      dvd_q       <= '0;
      qacc_q      <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      quot_q      <= '0;
      rem_q       <= '0;
      expo_out_q  <= '0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      d_q         <= d_d;
      r_q         <= r_d;
      dvd_q       <= dvd_d;
      qacc_q      <= qacc_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      quot_q      <= quot_d;
      rem_q       <= rem_d;
      expo_out_q  <= expo_out_d;
      ovf_q       <= ovf_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign quot      = quot_q;
  assign rem       = rem_q;
  assign expo_out  = expo_out_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_sequential_integral.sv
// Randomized self-checking bench for sequential_integral against an arithmetic reference model.
// Honors INTEGRAL_ROUND_EN in the model so it checks whichever build is compiled.
module tb_sequential_integral;
  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] coeff;
  logic [7:0] expo;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] quot;
  logic [7:0] rem;
  logic [7:0] expo_out;
  logic       ovf;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  sequential_integral dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .coeff(coeff), .expo(expo), .out_valid(out_valid), .out_ready(out_ready),
    .quot(quot), .rem(rem), .expo_out(expo_out), .ovf(ovf)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Expected {quot, rem, expo_out, ovf} from plain integer division.
  function automatic logic [24:0] model(input logic [7:0] c, input logic [7:0] e);
    int d;
    int q;
    int r;
    int eo;
    d = int'(e) + 1;
    q = int'(c) / d;
    r = int'(c) % d;
`ifdef INTEGRAL_ROUND_EN
    if (2 * r >= d) q = q + 1;
`endif
    eo = d % 256;
    return {q[7:0], r[7:0], eo[7:0], (e == 8'hFF)};
  endfunction

  task automatic run_term(input logic [7:0] c, input logic [7:0] e, input int stall);
    logic [24:0] exp_v;
    int lat;
    int exp_lat;
    exp_v   = model(c, e);
    exp_lat = (c == 8'd0) ? 1 : 8;
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL in_ready_idle: got %b want 1", in_ready);
    end
    in_valid = 1'b1; coeff = c; expo = e;
    @(posedge clk); #1;
    in_valid = 1'b0; coeff = 8'($urandom); expo = 8'($urandom);
    lat = 0;
    while (out_valid !== 1'b1 && lat < 20) begin
      n_checks++;
      if (in_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL in_ready_busy: got %b want 0 (cycle %0d)", in_ready, lat);
      end
      @(posedge clk); #1;
      lat++;
    end
    n_checks++;
    if (lat != exp_lat) begin
      n_fail++;
      $display("FAIL latency: got %0d want %0d (coeff=%0d expo=%0d)", lat, exp_lat, c, e);
    end
    n_checks++;
    if ({quot, rem, expo_out, ovf} !== exp_v) begin
      n_fail++;
      $display("FAIL result: got q=%0d r=%0d eo=%0d ovf=%b want q=%0d r=%0d eo=%0d ovf=%b (coeff=%0d expo=%0d)",
               quot, rem, expo_out, ovf, exp_v[24:17], exp_v[16:9], exp_v[8:1], exp_v[0], c, e);
    end
    for (int i = 0; i < stall; i++) begin
      in_valid = 1'b1; coeff = 8'($urandom); expo = 8'($urandom);
      @(posedge clk); #1;
      n_checks++;
      if ({out_valid, in_ready, quot, rem, expo_out, ovf} !== {1'b1, 1'b0, exp_v}) begin
        n_fail++;
        $display("FAIL stall_hold: got v=%b rdy=%b q=%0d r=%0d eo=%0d want v=1 rdy=0 q=%0d r=%0d eo=%0d",
                 out_valid, in_ready, quot, rem, expo_out, exp_v[24:17], exp_v[16:9], exp_v[8:1]);
      end
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    n_checks++;
    if ({out_valid, in_ready, quot, rem, expo_out, ovf} !== {1'b0, 1'b1, exp_v}) begin
      n_fail++;
      $display("FAIL handshake: got v=%b rdy=%b q=%0d r=%0d want v=0 rdy=1 q=%0d r=%0d",
               out_valid, in_ready, quot, rem, exp_v[24:17], exp_v[16:9]);
    end
    $display("term coeff=%0d expo=%0d stall=%0d -> quot=%0d rem=%0d expo_out=%0d ovf=%b latency=%0d",
             c, e, stall, quot, rem, expo_out, ovf, lat);
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; coeff = '0; expo = '0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({in_ready, out_valid, quot, rem, expo_out, ovf} !== {1'b1, 1'b0, 25'd0}) begin
      n_fail++;
      $display("FAIL reset_values: got rdy=%b v=%b q=%0d r=%0d eo=%0d ovf=%b want rdy=1 v=0 all 0",
               in_ready, out_valid, quot, rem, expo_out, ovf);
    end
    rst = 1'b0;
  endtask

  task automatic test_directed();
    run_term(8'd12, 8'd2, 0);
    run_term(8'd7, 8'd1, 0);
    run_term(8'd0, 8'd5, 0);
    run_term(8'd200, 8'd255, 0);
    run_term(8'd255, 8'd0, 5);
    run_term(8'd0, 8'd255, 1);
    run_term(8'd255, 8'd254, 0);
  endtask

  task automatic test_rst_mid_div();
    int seen;
    in_valid = 1'b1; coeff = 8'd200; expo = 8'd3;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    n_checks++;
    if ({in_ready, out_valid, quot, rem, expo_out, ovf} !== {1'b1, 1'b0, 25'd0}) begin
      n_fail++;
      $display("FAIL async_reset: got rdy=%b v=%b q=%0d r=%0d eo=%0d ovf=%b want rdy=1 v=0 all 0",
               in_ready, out_valid, quot, rem, expo_out, ovf);
    end
    #1 rst = 1'b0;
    seen = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b0) seen++;
    end
    n_checks++;
    if (seen != 0) begin
      n_fail++;
      $display("FAIL discarded_term: got out_valid high %0d cycles want 0", seen);
    end
    run_term(8'd9, 8'd2, 0);
  endtask

  task automatic test_back_to_back();
    int t0;
    int exp_cyc;
    for (int i = 0; i < 6; i++) begin
      logic [7:0] c;
      c = (i % 2 == 0) ? 8'($urandom_range(1, 255)) : 8'd0;
      exp_cyc = (c == 8'd0) ? 3 : 10;
      t0 = cyc;
      run_term(c, 8'($urandom), 0);
      n_checks++;
      if (cyc - t0 != exp_cyc) begin
        n_fail++;
        $display("FAIL throughput: got %0d cycles want %0d (coeff=%0d)", cyc - t0, exp_cyc, c);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++) begin
      logic [7:0] c;
      logic [7:0] e;
      c = ($urandom_range(0, 4) == 0) ? 8'd0 : 8'($urandom);
      e = ($urandom_range(0, 5) == 0) ? 8'hFF : 8'($urandom_range(0, 255));
      run_term(c, e, int'($urandom_range(0, 3)));
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_rst_mid_div();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
